// File: rtl/line_mem_pkg.sv
// Shared state encodings and width helpers for the line memory.
package line_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Bits needed to index n items, never less than one so ports stay legal.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line-wide storage with per-32-bit-word write enables and a registered read port.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int LINE_W = 256,
  parameter int WORDS  = 8,
  localparam int IDX_W = width_of(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [WORDS-1:0]  wmask_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] rdata_d;

  // Word-masked write; storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < WORDS; k++) begin
      if (we_i && wmask_i[k]) begin
        mem_q[idx_i][32*k +: 32] <= wdata_i[32*k +: 32];
      end
    end
  end

  // Read register only changes when a read is issued, so the last line is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  // Read output register, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Line-granular backing memory with configurable read/write latency, word
// write masking, busy indication and out-of-range error reporting.
module line_memory
  import line_mem_pkg::*;
#(
  parameter int LINE_BYTES = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 32,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 2,
  localparam int LINE_W    = 8 * LINE_BYTES,
  localparam int WORDS     = LINE_BYTES / 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic [WORDS-1:0]  wmask_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = width_of(DEPTH);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int CNT_W = width_of(max_of(READ_LAT, WRITE_LAT));
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  logic [TAG_W-1:0]  line_idx;
  logic [IDX_W-1:0]  idx_in;
  logic              oor_in;
  logic              unused_addr_bits;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WORDS-1:0]  mask_q, mask_d;
  logic              oor_q, oor_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;
  logic              access;
  logic              arr_we;
  logic              arr_re;
  logic [LINE_W-1:0] arr_rdata;

  assign line_idx         = addr_i[ADDR_W-1:OFF_W];
  assign idx_in           = line_idx[IDX_W-1:0];
  assign unused_addr_bits = ^addr_i[OFF_W-1:0];

  // Any set bit above the index field means the line lies beyond DEPTH.
  if (TAG_W > IDX_W) begin : g_range
    assign oor_in = |line_idx[TAG_W-1:IDX_W];
  end else begin : g_norange
    assign oor_in = 1'b0;
  end

  // Request FSM: capture in IDLE, count down latency in WAIT, drop ack in ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    line_d  = line_q;
    mask_d  = mask_q;
    oor_d   = oor_q;
    zero_d  = zero_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          write_d = write_i;
          idx_d   = idx_in;
          line_d  = data_i;
          mask_d  = wmask_i;
          oor_d   = oor_in;
          cnt_d   = write_i ? WR_LOAD : RD_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          ack_d   = 1'b1;
          err_d   = oor_q;
          state_d = ST_ACK;
          if (!write_q) begin
            zero_d = oor_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Array strobes are masked by reset so a reset on the access edge commits nothing.
  assign arr_we = access &&  write_q && !oor_q && !rst_i;
  assign arr_re = access && !write_q && !oor_q && !rst_i;

  // State, counter and capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      line_q  <= '0;
      mask_q  <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      mask_q  <= mask_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  line_mem_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .WORDS  (WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx_i   (idx_q),
    .we_i    (arr_we),
    .wmask_i (mask_q),
    .wdata_i (line_q),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  // An out-of-range read forces the returned line to zero until the next read.
  assign data_o = zero_q ? '0 : arr_rdata;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: a 2/2-latency instance and a 4/1 instance
// share stimulus wires but have separate enables.
module tb_line_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i;
  logic         en_a, en_b;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic [7:0]   wmask_i;
  logic         ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [255:0] dout_a, dout_b;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [255:0] P   = 256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_A5A50000;
  localparam logic [255:0] Q   = 256'h5A5A1007_5A5A1006_5A5A1005_5A5A1004_5A5A1003_5A5A1002_5A5A1001_5A5A1000;
  localparam logic [255:0] PQ0 = 256'hA5A50007_A5A50006_A5A50005_A5A50004_A5A50003_A5A50002_A5A50001_5A5A1000;

  line_memory #(.LINE_BYTES(32), .DEPTH(512), .ADDR_W(32), .READ_LAT(2), .WRITE_LAT(2)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .enable_i(en_a), .write_i(write_i), .addr_i(addr_i),
    .data_i(data_i), .wmask_i(wmask_i), .ack_o(ack_a), .data_o(dout_a), .busy_o(busy_a), .err_o(err_a)
  );

  line_memory #(.LINE_BYTES(32), .DEPTH(512), .ADDR_W(32), .READ_LAT(4), .WRITE_LAT(1)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .enable_i(en_b), .write_i(write_i), .addr_i(addr_i),
    .data_i(data_i), .wmask_i(wmask_i), .ack_o(ack_b), .data_o(dout_b), .busy_o(busy_b), .err_o(err_b)
  );

  // Issue one request and time acceptance -> ack; lat = 0 means no ack within 20 cycles.
  task automatic do_req(input bit sel, input bit scramble, input logic wr, input logic [31:0] addr,
                        input logic [255:0] data, input logic [7:0] mask,
                        output int lat, output logic [255:0] rdata, output logic err, output logic busy_ok);
    @(negedge clk);
    write_i = wr; addr_i = addr; data_i = data; wmask_i = mask;
    if (sel) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0;
    if (scramble) begin
      write_i = ~wr; addr_i = 32'h100; data_i = ~data; wmask_i = 8'hFF;
    end
    lat = 0; rdata = '0; err = 1'b0; busy_ok = 1'b1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        lat   = c;
        rdata = sel ? dout_b : dout_a;
        err   = sel ? err_b : err_a;
        if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_a = 1'b0; en_b = 1'b0; write_i = 1'b0;
    addr_i = '0; data_i = '0; wmask_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if (ack_a !== 1'b0) $display("[TB] FAIL reset_ack: got %b expected 0", ack_a); else pass_cnt++;
    chk_cnt++; if (err_a !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); else pass_cnt++;
    chk_cnt++; if (dout_a !== '0) $display("[TB] FAIL reset_data: got %h expected 0", dout_a); else pass_cnt++;
    chk_cnt++; if (busy_b !== 1'b0) $display("[TB] FAIL reset_busy_b: got %b expected 0", busy_b); else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] rd; logic err, bok;
    do_req(0, 0, 1'b1, 32'hA0, P, 8'hFF, lat, rd, err, bok);
    chk_cnt++; if (lat !== 2) $display("[TB] FAIL wr_lat: got %0d expected 2", lat); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("[TB] FAIL wr_err: got %b expected 0", err); else pass_cnt++;
    chk_cnt++; if (bok !== 1'b1) $display("[TB] FAIL wr_busy: got %b expected 1", bok); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'hA0, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (lat !== 2) $display("[TB] FAIL rd_lat: got %0d expected 2", lat); else pass_cnt++;
    chk_cnt++; if (rd !== P) $display("[TB] FAIL rd_data: got %h expected %h", rd, P); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("[TB] FAIL rd_err: got %b expected 0", err); else pass_cnt++;
    chk_cnt++; if (bok !== 1'b1) $display("[TB] FAIL rd_busy: got %b expected 1", bok); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (ack_a !== 1'b0) $display("[TB] FAIL ack_width: got %b expected 0", ack_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("[TB] FAIL busy_after: got %b expected 0", busy_a); else pass_cnt++;
    chk_cnt++; if (dout_a !== P) $display("[TB] FAIL data_hold: got %h expected %h", dout_a, P); else pass_cnt++;
  endtask

  task automatic test_mask();
    int lat; logic [255:0] rd; logic err, bok;
    do_req(0, 0, 1'b1, 32'h60, P, 8'hFF, lat, rd, err, bok);
    do_req(0, 0, 1'b1, 32'h60, Q, 8'h01, lat, rd, err, bok);
    chk_cnt++; if (dout_a !== P) $display("[TB] FAIL wr_keeps_data: got %h expected %h", dout_a, P); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'h60, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== PQ0) $display("[TB] FAIL mask_merge: got %h expected %h", rd, PQ0); else pass_cnt++;
    do_req(0, 0, 1'b1, 32'h60, Q, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (lat !== 2) $display("[TB] FAIL mask0_ack: got %0d expected 2", lat); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'h60, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== PQ0) $display("[TB] FAIL mask0_nochange: got %h expected %h", rd, PQ0); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [255:0] rd; logic err, bok;
    do_req(0, 0, 1'b1, 32'h0, Q, 8'hFF, lat, rd, err, bok);
    do_req(0, 0, 1'b1, 32'h4000, P, 8'hFF, lat, rd, err, bok);
    chk_cnt++; if (lat !== 2) $display("[TB] FAIL oor_wr_ack: got %0d expected 2", lat); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1) $display("[TB] FAIL oor_wr_err: got %b expected 1", err); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'h0, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== Q) $display("[TB] FAIL line0_intact: got %h expected %h", rd, Q); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("[TB] FAIL line0_err: got %b expected 0", err); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'h4000, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== '0) $display("[TB] FAIL oor_rd_data: got %h expected 0", rd); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1) $display("[TB] FAIL oor_rd_err: got %b expected 1", err); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (err_a !== 1'b0) $display("[TB] FAIL err_width: got %b expected 0", err_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [255:0] rd; logic err, bok; logic seen;
    do_req(0, 0, 1'b1, 32'hE0, P, 8'hFF, lat, rd, err, bok);
    @(negedge clk);
    write_i = 1'b1; addr_i = 32'hE0; data_i = Q; wmask_i = 8'hFF; en_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (ack_a !== 1'b0) $display("[TB] FAIL rstmid_ack: got %b expected 0", ack_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy_a); else pass_cnt++;
    rst_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack_a === 1'b1) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("[TB] FAIL rstmid_late_ack: got %b expected 0", seen); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'hE0, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== P) $display("[TB] FAIL rstmid_old_data: got %h expected %h", rd, P); else pass_cnt++;
  endtask

  task automatic test_capture();
    int lat; logic [255:0] rd; logic err, bok;
    do_req(0, 1, 1'b1, 32'h120, P, 8'hFF, lat, rd, err, bok);
    chk_cnt++; if (lat !== 2) $display("[TB] FAIL cap_wr_lat: got %0d expected 2", lat); else pass_cnt++;
    do_req(0, 0, 1'b0, 32'h120, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== P) $display("[TB] FAIL cap_data: got %h expected %h", rd, P); else pass_cnt++;
  endtask

  task automatic test_latency_b();
    int lat; logic [255:0] rd; logic err, bok;
    do_req(1, 0, 1'b1, 32'h40, P, 8'hFF, lat, rd, err, bok);
    chk_cnt++; if (lat !== 1) $display("[TB] FAIL b_wr_lat: got %0d expected 1", lat); else pass_cnt++;
    do_req(1, 0, 1'b0, 32'h40, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (lat !== 4) $display("[TB] FAIL b_rd_lat: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if (rd !== P) $display("[TB] FAIL b_rd_data: got %h expected %h", rd, P); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t [3]; int n; logic [255:0] rd; logic err, bok; int lat;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      write_i = (pass == 1); addr_i = 32'h40; data_i = Q; wmask_i = 8'h00; en_b = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (ack_b === 1'b1) begin t[n] = c; n++; end
      end
      en_b = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++; if (n !== 3) $display("[TB] FAIL b2b_count%0d: got %0d expected 3", pass, n); else pass_cnt++;
      chk_cnt++; if (n == 3 && (t[1] - t[0]) !== (pass ? 3 : 6))
        $display("[TB] FAIL b2b_gap%0d: got %0d expected %0d", pass, t[1] - t[0], pass ? 3 : 6); else pass_cnt++;
      chk_cnt++; if (n == 3 && (t[2] - t[1]) !== (pass ? 3 : 6))
        $display("[TB] FAIL b2b_gap2_%0d: got %0d expected %0d", pass, t[2] - t[1], pass ? 3 : 6); else pass_cnt++;
    end
    do_req(1, 0, 1'b0, 32'h40, '0, 8'h00, lat, rd, err, bok);
    chk_cnt++; if (rd !== P) $display("[TB] FAIL b2b_mask0: got %h expected %h", rd, P); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_out_of_range();
    test_reset_mid();
    test_capture();
    test_latency_b();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
